// File: rtl/fp_mul_arbiter.sv
// ============================================================================
//  Module      : fp_mul_arbiter
//  Description : Round-robin sharing of one single-precision multiplier among
//                NREQ requesters, with a valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    input  logic                 rsp_ready,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_out,
    output logic                 busy
);

    localparam int         c_cnt_w = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_calc  = 2'd1;
    localparam logic [1:0] c_resp  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [IDW-1:0]     r_last_grant;
    logic [IDW-1:0]     r_rsp_id;
    logic [IDW-1:0]     w_win;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_rsp_data;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [NREQ-1:0]    w_mask;
    logic [NREQ-1:0]    w_hi;
    logic [NREQ-1:0]    w_pick;
    logic [NREQ-1:0]    w_grant;
    logic               w_xfer;
    logic               w_done;

    // Requesters above the last winner are searched first; if none is
    // pending the search wraps to the full vector. Lowest set bit wins.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign w_mask[gi] = (IDW'(gi) > r_last_grant);
    end

    assign w_hi    = req_valid & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : req_valid;
    assign w_grant = w_pick & (~w_pick + NREQ'(1));

    always_comb begin
        w_win   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win   = IDW'(i);
                w_sel_a = req_a[32*i +: 32];
                w_sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign w_xfer = (r_state == c_idle) && (|req_valid);
    assign w_done = (r_state == c_calc) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (w_xfer)    w_state_next = c_calc;
            c_calc:  if (w_done)    w_state_next = c_resp;
            c_resp:  if (rsp_ready) w_state_next = c_idle;
            default:                w_state_next = c_idle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            c_idle:  req_ready = rst ? '0 : w_grant;
            c_calc:  busy      = 1'b1;
            c_resp: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: busy      = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_cnt        <= '0;
            r_last_grant <= IDW'(NREQ - 1);
        end else if (w_xfer) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_last_grant <= w_win;
            r_rsp_id     <= w_win;
            r_cnt        <= c_cnt_w'(MUL_LAT - 1);
        end else if (r_state == c_calc) begin
            if (w_done) begin
                r_rsp_data <= mul_out;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign mul_a    = r_op_a;
    assign mul_b    = r_op_b;
    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
// ============================================================================
//  Module      : tb_fp_mul_arbiter
//  Description : Self-checking bench for fp_mul_arbiter with a transaction
//                model and an attached reference single-precision multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 1;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_ready;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_out;
    logic              busy;

    logic              rst3;
    logic [NREQ-1:0]   req_valid3;
    logic [32*NREQ-1:0] req_a3;
    logic [32*NREQ-1:0] req_b3;
    logic [NREQ-1:0]   req_ready3;
    logic              rsp_valid3;
    logic [31:0]       rsp_data3;
    logic [1:0]        rsp_id3;
    logic              rsp_ready3;
    logic [31:0]       mul_a3;
    logic [31:0]       mul_b3;
    logic [31:0]       mul_out3;
    logic              busy3;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference IEEE-754 single multiply (normals and zeros, round-to-nearest-even)
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        logic [23:0] mr;
        logic        g;
        logic        st;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            m = p[45:23]; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) begin
            mr = {1'b0, m} + 24'd1;
            if (mr[23]) begin
                m = 23'd0; e = e + 1;
            end else begin
                m = mr[22:0];
            end
        end
        return {s, e[7:0], m};
    endfunction

    function automatic int rr(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        $display("FAIL %s: timed out waiting, got none required event", nm);
    endtask

    assign mul_out  = fmul(mul_a, mul_b);
    assign mul_out3 = fmul(mul_a3, mul_b3);

    fp_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_out(mul_out), .busy(busy)
    );

    fp_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .rsp_id(rsp_id3), .rsp_ready(rsp_ready3), .mul_a(mul_a3), .mul_b(mul_b3),
        .mul_out(mul_out3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: one operation in flight, m_age counts cycles since accept
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_id   = 0;
    int          m_last = NREQ - 1;
    logic [31:0] m_opa  = '0;
    logic [31:0] m_opb  = '0;

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_busy <= 1'b0; m_age <= 0; m_id <= 0; m_last <= NREQ - 1;
            m_opa  <= '0;   m_opb <= '0;
        end else if (!m_busy) begin
            g = rr(req_valid, m_last);
            if (g >= 0) begin
                m_busy <= 1'b1; m_age <= 1; m_id <= g; m_last <= g;
                m_opa  <= req_a[32*g +: 32];
                m_opb  <= req_b[32*g +: 32];
            end
        end else if (m_age > MUL_LAT) begin
            if (rsp_ready) m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        int              g;
        bit              exp_rv;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
        end else begin
            exp_ready = '0;
            if (!m_busy) begin
                g = rr(req_valid, m_last);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            exp_rv = m_busy && (m_age > MUL_LAT);
            chk("cyc_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("cyc_mul_a", mul_a, m_opa);
            chk("cyc_mul_b", mul_b, m_opb);
            if (exp_rv) begin
                chk("cyc_rsp_data", rsp_data, fmul(m_opa, m_opb));
                chk("cyc_rsp_id", 32'(rsp_id), 32'(m_id));
            end
        end
    end

    int          grant_q[$];
    int          rid_q[$];
    logic [31:0] rdata_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                rid_q.push_back(int'(rsp_id));
                rdata_q.push_back(rsp_data);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
            end
        end
    end

    task automatic wait_ready(input int id, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout(nm);
    endtask

    task automatic wait_rsp(input int n, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rid_q.size() >= n) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) timeout(nm);
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input string nm);
        @(posedge clk); #1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]      = 1'b1;
        wait_ready(id, nm);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    logic [31:0] exp_data [12] = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h00000000,
                                   32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                   32'h40000000, 32'h40800000, 32'h41100000, 32'h40000000};
    int          exp_id   [12] = '{0, 2, 1, 3, 0, 1, 2, 3, 0, 1, 2, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  got;
        rst = 1'b1; rst3 = 1'b1;
        req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
        #2;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mul_a", mul_a, 32'd0);
        chk("reset_mul_b", mul_b, 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (8) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        // Basic product with latency measured from the transfer edge
        @(posedge clk); #1;
        req_a[31:0] = 32'h40000000; req_b[31:0] = 32'h40400000; req_valid[0] = 1'b1;
        wait_ready(0, "basic_grant");
        @(posedge clk); #1 req_valid[0] = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("basic_latency", 32'(lat), 32'd2);
        wait_rsp(1, "basic_rsp");

        issue(2, 32'h3FC00000, 32'h3FC00000, "round_grant");
        wait_rsp(2, "round_rsp");
        issue(1, 32'hC0000000, 32'h40400000, "sign_grant");
        wait_rsp(3, "sign_rsp");
        issue(3, 32'h00000000, 32'h3F800000, "zero_grant");
        wait_rsp(4, "zero_rsp");

        // Fairness: all requesters continuously valid for six grants
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = (i == 0) ? 32'h3F800000 : (i == 1) ? 32'h40000000 :
                                (i == 2) ? 32'h40400000 : 32'h40800000;
            req_b[32*i +: 32] = 32'h40000000;
        end
        req_valid = '1;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (grant_q.size() >= 10) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("fair_grants");
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(10, "fair_rsp");

        // Backpressure with a second requester waiting
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_a[95:64] = 32'h40400000; req_b[95:64] = 32'h40400000;
        req_a[31:0]  = 32'h3F000000; req_b[31:0]  = 32'h40800000;
        req_valid = 4'b0101;
        wait_ready(2, "bp_grant");
        @(posedge clk); #1 req_valid[2] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("bp_rsp_valid");
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h41100000);
            chk("bp_rsp_id", 32'(rsp_id), 32'd2);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_ready(0, "bp_next_grant");
        chk("bp_next_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_rsp(12, "bp_final_rsp");

        chk("rsp_count", 32'(rid_q.size()), 32'd12);
        chk("grant_count", 32'(grant_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < rid_q.size()) begin
                chk("seq_rsp_data", rdata_q[i], exp_data[i]);
                chk("seq_rsp_id", 32'(rid_q[i]), 32'(exp_id[i]));
            end
            if (i < grant_q.size()) chk("seq_grant", 32'(grant_q[i]), 32'(exp_id[i]));
        end

        // Reset in the middle of a three-cycle calculation
        @(posedge clk); #1;
        rst3 = 1'b0;
        req_a3[31:0] = 32'h40000000; req_b3[31:0] = 32'h40400000; req_valid3 = 4'b0001;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready3[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("lat3_grant");
        @(posedge clk); #1 req_valid3 = '0;
        @(posedge clk); #1;
        chk("lat3_busy_calc", 32'(busy3), 32'd1);
        chk("lat3_mul_a_calc", mul_a3, 32'h40000000);
        #2;
        rst3 = 1'b1; req_valid3 = 4'b0011;
        #1;
        chk("lat3_rst_rsp_valid", 32'(rsp_valid3), 32'd0);
        chk("lat3_rst_busy", 32'(busy3), 32'd0);
        chk("lat3_rst_mul_a", mul_a3, 32'd0);
        chk("lat3_rst_mul_b", mul_b3, 32'd0);
        chk("lat3_rst_rsp_data", rsp_data3, 32'd0);
        chk("lat3_rst_rsp_id", 32'(rsp_id3), 32'd0);
        chk("lat3_rst_req_ready", 32'(req_ready3), 32'd0);
        @(posedge clk); #1 rst3 = 1'b0;
        @(negedge clk);
        chk("lat3_priority", 32'(req_ready3), 32'd1);
        @(posedge clk); #1 req_valid3 = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat3_no_rsp", 32'(rsp_valid3), 32'd0);
        end
        @(negedge clk);
        chk("lat3_rsp_valid", 32'(rsp_valid3), 32'd1);
        chk("lat3_rsp_id", 32'(rsp_id3), 32'd0);
        chk("lat3_rsp_data", rsp_data3, 32'h40C00000);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
